// File: rtl/memory_stage_wb_cache_if.sv
// RAM-side bus of the memory stage.
// One request at a time: ram_req opens a transaction and ram_we, ram_addr and
// ram_wd stay stable with it. The transaction completes in the cycle where
// ram_req=1 and ram_ack=1; that can be the first request cycle. When ram_we=0,
// ram_rdata is valid in that same cycle. ram_ack while ram_req=0 means nothing.
// If ram_req drops without an ack, the RAM discards the request.
//   master : cache side (drives req/we/addr/wd)
//   slave  : RAM side   (drives rdata/ack)
interface memory_stage_wb_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_ack;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wd,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wd,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/memory_stage_wb_cache.sv
// Memory stage with a direct-mapped, write-back, write-allocate data cache.
// Each line holds one word. A hit completes in the same cycle. On a miss, Stall
// is raised while the victim is written back (if it is dirty) and the line is
// refilled from RAM. The final 4:1 mux produces the register file write data.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   MemRead/MemWrite     access request (store wins if both are set)
//   AccessMode           funct3 size/sign select
//   ResultSrc            result mux select
//   PCPlus4, ImmExt      result mux inputs
//   ALUResult            byte address, also a result mux input
//   WriteData            store data, right-aligned
//   Result               register file WD3
//   Stall                pipeline freeze
//   dbg_state            FSM state (0 IDLE, 1 WRITEBACK, 2 REFILL)
//   ram                  RAM bus (master side)
module memory_stage_wb_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            AccessMode,
  input  logic [1:0]            ResultSrc,
  input  logic [DATA_WIDTH-1:0] PCPlus4,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Stall,
  output logic [1:0]            dbg_state,
  memory_stage_wb_cache_if.master ram
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;
  state_t state;

  logic [SETS-1:0]       valid;
  logic [SETS-1:0]       dirty;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  logic [1:0]            off;
  logic [SET_BITS-1:0]   idx;
  logic [TAG_W-1:0]      tag;
  logic [DATA_WIDTH-1:0] line;
  logic                  access, hit, miss;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] merged;

  assign off    = ALUResult[1:0];
  assign idx    = ALUResult[SET_BITS+1:2];
  assign tag    = ALUResult[ADDR_WIDTH-1:SET_BITS+2];
  assign line   = data_mem[idx];
  assign access = MemRead | MemWrite;
  // A hit is only recognised in IDLE. The refilled line becomes visible in the
  // IDLE cycle after the refill ack.
  assign hit    = access & (state == IDLE) & valid[idx] & (tag_mem[idx] == tag);
  assign miss   = access & (state == IDLE) & ~hit;
  assign Stall  = ~rst & ((state != IDLE) | miss);
  assign dbg_state = state;

  // Load extraction. AccessMode[2] selects zero extension.
  assign rd_byte = line[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? line[31:16] : line[15:0];

  always_comb begin
    read_data = line;
    case (AccessMode)
      3'b000:  read_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  read_data = {24'h0, rd_byte};
      3'b001:  read_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  read_data = {16'h0, rd_half};
      default: read_data = line;
    endcase
  end

  // Store byte-lane merge into the current line.
  always_comb begin
    merged = line;
    case (AccessMode[1:0])
      2'b00: merged[{off, 3'b000} +: 8] = WriteData[7:0];
      2'b01: begin
        if (off[1]) merged[31:16] = WriteData[15:0];
        else        merged[15:0]  = WriteData[15:0];
      end
      default: merged = WriteData;
    endcase
  end

  always_comb begin
    Result = DATA_WIDTH'(ALUResult);
    case (ResultSrc)
      2'b00:   Result = DATA_WIDTH'(ALUResult);
      2'b01:   Result = read_data;
      2'b10:   Result = PCPlus4;
      default: Result = ImmExt;
    endcase
  end

  // Control FSM plus valid/dirty bits. The RAM outputs are registered, so they
  // stay stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ram.ram_req  <= 1'b0;
      ram.ram_we   <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_wd   <= '0;
      valid        <= '0;
      dirty        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            ram.ram_req <= 1'b1;
            if (valid[idx] & dirty[idx]) begin
              state        <= WRITEBACK;
              ram.ram_we   <= 1'b1;
              ram.ram_addr <= {tag_mem[idx], idx, 2'b00};
              ram.ram_wd   <= line;
            end else begin
              state        <= REFILL;
              ram.ram_we   <= 1'b0;
              ram.ram_addr <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            end
          end else if (hit & MemWrite) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          // req stays high: the refill read follows the write-back directly.
          if (ram.ram_ack) begin
            state        <= REFILL;
            ram.ram_we   <= 1'b0;
            ram.ram_addr <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        REFILL: begin
          if (ram.ram_ack) begin
            state       <= IDLE;
            ram.ram_req <= 1'b0;
            valid[idx]  <= 1'b1;
            dirty[idx]  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          ram.ram_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage have no reset. Reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit & MemWrite) begin
        data_mem[idx] <= merged;
      end else if ((state == REFILL) & ram.ram_ack) begin
        data_mem[idx] <= ram.ram_rdata;
        tag_mem[idx]  <= tag;
      end
    end
  end
endmodule

// File: doc/memory_stage_wb_cache.md
Name: memory_stage_wb_cache

Overview:
Next-generation memory stage. It replaces the single-cycle cache/RAM pair with a parametrised, direct-mapped, write-back, write-allocate data cache, and talks to a variable-latency RAM over a req/ack handshake. Hits complete in the same cycle. Misses raise Stall to the pipeline until the line is refilled. Supports byte, half and word loads and stores with sign or zero extension, and ends with the usual 4:1 result mux feeding WD3 of the register file.

Parameters:
DATA_WIDTH, 32, data/word width in bits (fixed 32 for byte-lane logic)
ADDR_WIDTH, 32, byte address width
SET_BITS, 6, log2 of number of cache sets (default 64 sets, one 32-bit word per line)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
MemRead  in  1  load request this cycle
MemWrite  in  1  store request this cycle
AccessMode  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ResultSrc  in  2  00 ALUResult, 01 ReadData, 10 PCPlus4, 11 ImmExt
PCPlus4  in  DATA_WIDTH  result mux input
ImmExt  in  DATA_WIDTH  result mux input
ALUResult  in  ADDR_WIDTH  byte address of access; also result mux input
WriteData  in  DATA_WIDTH  store data, right-aligned
Result  out  DATA_WIDTH  to register file WD3
Stall  out  1  freeze upstream pipeline while 1
ram_req  out  1  RAM transaction request
ram_we  out  1  1 = write-back, 0 = refill read
ram_addr  out  ADDR_WIDTH  word-aligned RAM address (bits [1:0] = 00)
ram_wd  out  DATA_WIDTH  write-back data
ram_rdata  in  DATA_WIDTH  refill data, valid when ram_ack=1 and ram_we=0
ram_ack  in  1  one-cycle completion pulse for the current request

Behaviour:
- Address split: offset [1:0], index [SET_BITS+1:2], tag [ADDR_WIDTH-1:SET_BITS+2].
- Per-set state: valid, dirty, tag, 32-bit data.
- Access = MemRead | MemWrite. If both are set, the access is treated as a store.
- Hit = access & valid[index] & tag match. Evaluated combinationally.
- Load hit: ReadData is available the same cycle, and Stall=0.
- Load extraction:
  - LB/LBU select byte offset.
  - LH/LHU select the half at offset[1], ignoring offset[0].
  - LW ignores the offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store hit:
  - Byte-lane merge of WriteData[7:0] / [15:0] / [31:0] into the line at the rising edge.
  - dirty set to 1. Stall=0.
  - No RAM traffic.
- Miss: Stall=1 combinationally in the same cycle. The FSM leaves IDLE at the next edge.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE -> WRITEBACK on a miss with the victim valid & dirty.
  - IDLE -> REFILL on a miss with a clean or invalid victim.
  - WRITEBACK:
    - Drives ram_req=1, ram_we=1, ram_addr={victim tag, index, 00}, ram_wd=line data.
    - Goes to REFILL on ram_ack.
  - REFILL:
    - Drives ram_req=1, ram_we=0, ram_addr={ALUResult[ADDR_WIDTH-1:2], 00}.
    - On ram_ack, writes the line with ram_rdata, tag, valid=1, dirty=0, then returns to IDLE.
  - In IDLE, the next cycle re-evaluates the access and hits. A store merges in that hit cycle.
- Stall stays 1 in WRITEBACK and REFILL, and in the miss-detect IDLE cycle. It drops in the first hit cycle.
- Clean-miss latency: 1 + (cycles until ack) + 1 hit cycle. Dirty miss adds the write-back ack wait.
- ram_req, ram_we, ram_addr and ram_wd are held stable until ram_ack. An ack arriving in the first req cycle is accepted. ram_ack outside ram_req is ignored.
- The pipeline holds ALUResult, AccessMode, MemRead, MemWrite and WriteData stable while Stall=1. The block does not latch them.
- Reset:
  - Clears all valid and dirty bits at the next edge (tags and data unchanged).
  - FSM goes to IDLE. ram_req=0, ram_we=0, ram_addr=0, ram_wd=0.
  - Stall=0 unless an access is presented with rst low.
- Reset mid-WRITEBACK/REFILL: the transaction is abandoned and ram_req drops the next cycle. The RAM discards an outstanding request when req drops. A late ack is ignored.
- No access (MemRead=MemWrite=0): Stall=0, no state change. ReadData is don't-care, but Result still follows ResultSrc.
- Result mux is purely combinational: 00 ALUResult, 01 ReadData, 10 PCPlus4, 11 ImmExt.

Test Plan:
1. Cold load: after rst, LW addr 0x100, RAM acks 3 cycles after req with 0xDEADBEEF -> Stall=1 for 5 cycles, one ram_req read at 0x100, then Result=0xDEADBEEF (ResultSrc=01) with Stall=0.
2. Hit sub-word loads at 0x100 holding 0xDEADBEEF:
   - LB at 0x103 -> 0xFFFFFFDE
   - LBU at 0x103 -> 0x000000DE
   - LH at 0x102 -> 0xFFFFDEAD
   - LHU at 0x100 -> 0x0000BEEF
   - Each with Stall=0 and no ram_req.
3. Store hit then eviction: SB 0x55 to 0x101, then LW at 0x100 + (1<<(SET_BITS+2)) = 0x200 -> write-back ram_we=1, ram_addr=0x100, ram_wd=0xDEAD55EF, then refill read at 0x200.
4. Dirty store-miss: SW 0x12345678 to a clean invalid set -> refill read, then merge. A subsequent eviction writes back 0x12345678. Immediate ack (same cycle as req) is accepted.
5. Reset mid-REFILL: assert rst with req pending, ack withheld -> ram_req=0 next cycle, Stall=0. A late ram_ack causes no line update. Reload of the same address misses.
6. Result mux: MemRead=MemWrite=0, ResultSrc 00/10/11 with ALUResult=0x10, PCPlus4=0x24, ImmExt=0xFFFFFFF0 -> Result=0x10/0x24/0xFFFFFFF0, Stall=0.
